// File: rtl/nios2_qsys_mul_sequencer_if.sv
// Request/response handshake bundle for the multiply sequencer.
// master: the requesting side (drives requests, accepts results).
// slave:  the sequencer itself.
interface nios2_qsys_mul_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;

  modport master (
    output req_valid, req_op, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/nios2_qsys_mul_sequencer.sv
// Control stage in front of the Nios II 32x32 low-word multiply cell.
// MUL issues one 32x32 product; MULXSS/MULXSU/MULXUU issue four
// zero-extended 16x16 half products, accumulate a 64-bit unsigned
// product, then apply the signed correction to the high word.
// Optional build macro: NIOS2_MULSEQ_ZERO_SKIP_EN answers requests with a
// zero operand directly (result 0, one cycle, cell untouched).
module nios2_qsys_mul_sequencer #(
  parameter int CELL_LATENCY = 1
) (
  input  logic                        clk,
  input  logic                        reset_n,
  nios2_qsys_mul_sequencer_if.slave   bus,
  output logic [31:0]                 A_mul_src1,
  output logic [31:0]                 A_mul_src2,
  input  logic [31:0]                 A_mul_cell_result
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_DRAIN, S_CORR, S_DONE} state_t;

  state_t                state, state_nxt;
  logic [1:0]            op_q;
  logic [31:0]           a_q, b_q;
  logic [1:0]            iss_cnt, smp_cnt;
  logic [63:0]           acc;
  logic [CELL_LATENCY:0] iss_vld_p;
  logic [31:0]           resp_data_q;
  logic                  accept, is_mul, last_iss, sample, last_smp, zero_op;

  // Shifted contribution of the k-th half product to the 64-bit sum.
  function automatic logic [63:0] acc_term(input logic [31:0] p, input logic [1:0] k);
    case (k)
      2'd0:    acc_term = {32'b0, p};
      2'd3:    acc_term = {p, 32'b0};
      default: acc_term = {16'b0, p, 16'b0};
    endcase
  endfunction

  // Turn the unsigned high word into the signed/mixed high word, mod 2^32.
  function automatic logic [31:0] hi_correct(input logic [1:0] op, input logic [31:0] hi,
                                             input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ca, cb;
    ca = a[31] ? b : 32'd0;
    cb = b[31] ? a : 32'd0;
    case (op)
      2'd1:    hi_correct = hi - (ca + cb);
      2'd2:    hi_correct = hi - ca;
      default: hi_correct = hi;
    endcase
  endfunction

  assign accept   = (state == S_IDLE) && bus.req_valid;
  assign is_mul   = (op_q == 2'd0);
  assign last_iss = is_mul || (iss_cnt == 2'd3);
  assign sample   = iss_vld_p[CELL_LATENCY];
  assign last_smp = sample && (is_mul || (smp_cnt == 2'd3));
`ifdef NIOS2_MULSEQ_ZERO_SKIP_EN
  assign zero_op  = (bus.req_a == 32'd0) || (bus.req_b == 32'd0);
`else
  assign zero_op  = 1'b0;
`endif

  assign bus.req_ready  = (state == S_IDLE);
  assign bus.resp_valid = (state == S_DONE);
  assign bus.resp_data  = resp_data_q;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = zero_op ? S_DONE : S_ISSUE;
      S_ISSUE: if (last_iss) state_nxt = S_DRAIN;
      S_DRAIN: if (last_smp) state_nxt = S_CORR;
      S_CORR:  state_nxt = S_DONE;
      S_DONE:  if (bus.resp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Request latch and issue: drive one operand pair per ISSUE cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q       <= 2'd0;
      a_q        <= 32'd0;
      b_q        <= 32'd0;
      iss_cnt    <= 2'd0;
      A_mul_src1 <= 32'd0;
      A_mul_src2 <= 32'd0;
    end else if (accept) begin
      op_q    <= bus.req_op;
      a_q     <= bus.req_a;
      b_q     <= bus.req_b;
      iss_cnt <= 2'd0;
    end else if (state == S_ISSUE) begin
      iss_cnt <= iss_cnt + 2'd1;
      if (is_mul) begin
        A_mul_src1 <= a_q;
        A_mul_src2 <= b_q;
      end else begin
        A_mul_src1 <= {16'b0, iss_cnt[0] ? a_q[31:16] : a_q[15:0]};
        A_mul_src2 <= {16'b0, iss_cnt[1] ? b_q[31:16] : b_q[15:0]};
      end
    end
  end

  // Issue valid travels with the cell pipeline; tap marks a result to sample.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) iss_vld_p <= '0;
    else          iss_vld_p <= {iss_vld_p[CELL_LATENCY-1:0], state == S_ISSUE};
  end

  // Accumulate sampled cell results.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc     <= 64'd0;
      smp_cnt <= 2'd0;
    end else if (accept) begin
      acc     <= 64'd0;
      smp_cnt <= 2'd0;
    end else if (sample) begin
      acc     <= acc + acc_term(A_mul_cell_result, smp_cnt);
      smp_cnt <= smp_cnt + 2'd1;
    end
  end

  // Result word: corrected in CORR, forced to zero on a skipped request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      resp_data_q <= 32'd0;
    end else if (accept && zero_op) begin
      resp_data_q <= 32'd0;
    end else if (state == S_CORR) begin
      resp_data_q <= is_mul ? acc[31:0] : hi_correct(op_q, acc[63:32], a_q, b_q);
    end
  end

endmodule

// File: tb/tb_nios2_qsys_mul_sequencer.sv
// Directed bench for nios2_qsys_mul_sequencer with a behavioural
// CELL_LATENCY-stage multiply cell.
module tb_nios2_qsys_mul_sequencer;
  localparam int L = 1;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] src1, src2, cell_res;
  logic [31:0] cell_p [L];

  always #5 clk = ~clk;

  nios2_qsys_mul_sequencer_if bus ();

  nios2_qsys_mul_sequencer #(.CELL_LATENCY(L)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .bus               (bus),
    .A_mul_src1        (src1),
    .A_mul_src2        (src2),
    .A_mul_cell_result (cell_res)
  );

  // Multiply cell model: low word of the product, L register stages.
  always @(posedge clk) begin
    cell_p[0] <= src1 * src2;
    for (int i = 1; i < L; i++) cell_p[i] <= cell_p[i-1];
  end
  assign cell_res = cell_p[L-1];

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic int exp_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef NIOS2_MULSEQ_ZERO_SKIP_EN
    if (a == 32'd0 || b == 32'd0) return 1;
`endif
    return (op == 2'd0) ? L + 3 : L + 6;
  endfunction

  // Issue one request and wait for resp_valid; returns data and latency.
  task automatic run_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] data, output int lat);
    int w;
    w = 0;
    @(negedge clk);
    while (!bus.req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("req_ready_wait", {31'b0, bus.req_ready}, 32'd1);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      #1 lat++;
      if (bus.resp_valid) break;
    end
    chk("resp_timeout", {31'b0, bus.resp_valid}, 32'd1);
    data = bus.resp_data;
  endtask

  // After a response with resp_ready=1, the next edge returns to IDLE.
  task automatic chk_handshake(input string name);
    @(posedge clk);
    #1;
    chk({name, "_vld_drop"}, {31'b0, bus.resp_valid}, 32'd0);
    chk({name, "_idle"}, {31'b0, bus.req_ready}, 32'd1);
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [12];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int          lat;
    int          saw;
    logic [31:0] exp_s1, exp_s2;

    vecs[0]  = '{2'd0, 32'd7,         32'd6,         32'h0000002A};
    vecs[1]  = '{2'd3, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'hFFFFFFFE};
    vecs[2]  = '{2'd1, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'h00000000};
    vecs[3]  = '{2'd1, 32'h80000000,  32'h80000000,  32'h40000000};
    vecs[4]  = '{2'd2, 32'hFFFFFFFF,  32'h00000002,  32'hFFFFFFFF};
    vecs[5]  = '{2'd0, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'h00000001};
    vecs[6]  = '{2'd3, 32'h00010000,  32'h00010000,  32'h00000001};
    vecs[7]  = '{2'd2, 32'h12345678,  32'h00000010,  32'h00000001};
    vecs[8]  = '{2'd1, 32'hFFFFFFFE,  32'h00000003,  32'hFFFFFFFF};
    vecs[9]  = '{2'd0, 32'h00000000,  32'h00000005,  32'h00000000};
    vecs[10] = '{2'd2, 32'h7FFFFFFF,  32'hFFFFFFFF,  32'h7FFFFFFE};
    vecs[11] = '{2'd0, 32'h12345678,  32'h00000100,  32'h34567800};

    bus.req_valid  = 1'b0;
    bus.req_op     = 2'd0;
    bus.req_a      = 32'd0;
    bus.req_b      = 32'd0;
    bus.resp_ready = 1'b1;
    reset_n        = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready",  {31'b0, bus.req_ready},  32'd1);
    chk("rst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    chk("rst_resp_data",  bus.resp_data, 32'd0);
    chk("rst_src1", src1, 32'd0);
    chk("rst_src2", src2, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < 12; i++) begin
      run_req(vecs[i].op, vecs[i].a, vecs[i].b, d, lat);
      chk($sformatf("vec%0d_data", i), d, vecs[i].exp);
      chk($sformatf("vec%0d_lat", i), lat, exp_lat(vecs[i].op, vecs[i].a, vecs[i].b));
      chk_handshake($sformatf("vec%0d", i));
    end

    // Operands hold after the last MUL issue
    chk("hold_src1", src1, 32'h12345678);
    chk("hold_src2", src2, 32'h00000100);

    // Zero operand high op: skipped or normal path
    run_req(2'd3, 32'd0, 32'h00001234, d, lat);
    chk("zero_data", d, 32'd0);
`ifdef NIOS2_MULSEQ_ZERO_SKIP_EN
    chk("zero_lat", lat, 32'd1);
    exp_s1 = 32'h12345678;
    exp_s2 = 32'h00000100;
`else
    chk("zero_lat", lat, L + 6);
    exp_s1 = 32'd0;
    exp_s2 = 32'd0;
`endif
    chk("zero_src1", src1, exp_s1);
    chk("zero_src2", src2, exp_s2);
    chk_handshake("zero");

    // Backpressure: hold response for 5 cycles
    bus.resp_ready = 1'b0;
    run_req(2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, d, lat);
    chk("bp_data", d, 32'hFFFFFFFE);
    chk("bp_lat", lat, L + 6);
    chk("bp_src1", src1, 32'h0000FFFF);
    chk("bp_src2", src2, 32'h0000FFFF);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("bp%0d_vld", i),   {31'b0, bus.resp_valid}, 32'd1);
      chk($sformatf("bp%0d_data", i),  bus.resp_data, 32'hFFFFFFFE);
      chk($sformatf("bp%0d_ready", i), {31'b0, bus.req_ready}, 32'd0);
    end
    @(negedge clk);
    bus.resp_ready = 1'b1;
    chk_handshake("bp");

    // Reset during the third half-product issue
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = 2'd1;
    bus.req_a     = 32'h12345678;
    bus.req_b     = 32'h9ABCDEF0;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("ar_req_ready",  {31'b0, bus.req_ready},  32'd1);
    chk("ar_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    chk("ar_resp_data",  bus.resp_data, 32'd0);
    chk("ar_src1", src1, 32'd0);
    chk("ar_src2", src2, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    saw = 0;
    repeat (10) begin
      @(posedge clk);
      #1 if (bus.resp_valid) saw++;
    end
    chk("ar_no_resp", saw, 32'd0);
    run_req(2'd1, 32'h80000000, 32'h80000000, d, lat);
    chk("ar_after_data", d, 32'h40000000);
    chk("ar_after_lat", lat, L + 6);
    chk_handshake("ar_after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
